abro_stimulus_gen: RTL and testbench

//  Transmit-side counterpart of the ABRO sequence detector. On request, drives the
//  A/B lines through the accepted pattern (A&B, then A&!B, then !A&B) for a

---
 rtl/abro_pkg.sv | 29 ++
 rtl/abro_stimulus_gen_if.sv | 27 ++
 rtl/abro_phase_timer.sv | 31 +++
 rtl/abro_stimulus_gen.sv | 127 ++++++++++++
 tb/tb_abro_stimulus_gen.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/abro_pkg.sv
// rtl/abro_pkg.sv - shared state encoding and A/B drive levels for the ABRO stimulus generator
package abro_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PH_AB = 3'd1,
      PH_A  = 3'd2,
      PH_B  = 3'd3,
      CHECK = 3'd4
   } state_t;

   localparam logic [1:0] AB_IDLE  = 2'b00;
   localparam logic [1:0] AB_PH_AB = 2'b11;
   localparam logic [1:0] AB_PH_A  = 2'b10;
   localparam logic [1:0] AB_PH_B  = 2'b01;
   localparam logic [1:0] AB_CHECK = 2'b00;

   // {A,B} levels presented to the detector while in a given state
   function automatic logic [1:0] ab_drive(input state_t s);
      case (s)
         PH_AB:   ab_drive = AB_PH_AB;
         PH_A:    ab_drive = AB_PH_A;
         PH_B:    ab_drive = AB_PH_B;
         CHECK:   ab_drive = AB_CHECK;
         default: ab_drive = AB_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/abro_stimulus_gen_if.sv
// rtl/abro_stimulus_gen_if.sv - control/status and detector lines of the ABRO stimulus generator
interface abro_stimulus_gen_if #(
   parameter int HOLD_W = 4,
   parameter int REPS_W = 4
) ();
   logic              start;
   logic              abort;
   logic [HOLD_W-1:0] hold_cycles;
   logic [REPS_W-1:0] reps;
   logic              o_in;
   logic              A;
   logic              B;
   logic              busy;
   logic              done;
   logic [REPS_W-1:0] match_count;
   logic              err;

   modport master (
      output start, abort, hold_cycles, reps, o_in,
      input  A, B, busy, done, match_count, err
   );

   modport slave (
      input  start, abort, hold_cycles, reps, o_in,
      output A, B, busy, done, match_count, err
   );
endinterface

// File: rtl/abro_phase_timer.sv
// rtl/abro_phase_timer.sv - phase length down-counter; expire marks the last cycle of a phase
module abro_phase_timer #(
   parameter int HOLD_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [HOLD_W-1:0] load_val,
   output logic              expire
);
   logic [HOLD_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - HOLD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == HOLD_W'(1));
endmodule

// File: rtl/abro_stimulus_gen.sv
// rtl/abro_stimulus_gen.sv - drives A/B through the ABRO pattern for reps repetitions and scores o_in
module abro_stimulus_gen
   import abro_pkg::*;
#(
   parameter int HOLD_W = 4,
   parameter int REPS_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   abro_stimulus_gen_if.slave   bus
);
   state_t            state_q, state_d;
   logic [HOLD_W-1:0] h_q, h_d;
   logic [REPS_W-1:0] rem_q, rem_d;
   logic [REPS_W-1:0] match_q, match_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic [1:0]        ab_q, ab_d;
   logic              load;
   logic [HOLD_W-1:0] load_val;
   logic [HOLD_W-1:0] hold_eff;
   logic              expire;

   assign hold_eff = (bus.hold_cycles == '0) ? HOLD_W'(1) : bus.hold_cycles;

   abro_phase_timer #(.HOLD_W(HOLD_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .expire   (expire)
   );

   always_comb begin
      state_d  = state_q;
      h_d      = h_q;
      rem_d    = rem_q;
      match_d  = match_q;
      err_d    = err_q;
      done_d   = 1'b0;
      load     = 1'b0;
      load_val = h_q;
      case (state_q)
         IDLE: begin
            if (bus.start && (bus.reps != '0)) begin
               state_d  = PH_AB;
               h_d      = hold_eff;
               rem_d    = bus.reps;
               match_d  = '0;
               err_d    = 1'b0;
               load     = 1'b1;
               load_val = hold_eff;
            end
         end
         PH_AB: begin
            if (expire) begin
               state_d = PH_A;
               load    = 1'b1;
            end
         end
         PH_A: begin
            if (expire) begin
               state_d = PH_B;
               load    = 1'b1;
            end
         end
         PH_B: begin
            if (expire) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (bus.o_in) begin
               match_d = match_q + REPS_W'(1);
            end else begin
               err_d = 1'b1;
            end
            rem_d = rem_q - REPS_W'(1);
            if (rem_q == REPS_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = PH_AB;
               load    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // abort overrides every transition and freezes the score
      if (bus.abort && (state_q != IDLE)) begin
         state_d = IDLE;
         rem_d   = rem_q;
         match_d = match_q;
         err_d   = err_q;
         done_d  = 1'b0;
         load    = 1'b0;
      end
      ab_d = ab_drive(state_d);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         h_q     <= HOLD_W'(1);
         rem_q   <= '0;
         match_q <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         ab_q    <= AB_IDLE;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         rem_q   <= rem_d;
         match_q <= match_d;
         err_q   <= err_d;
         done_q  <= done_d;
         ab_q    <= ab_d;
      end
   end

   assign bus.A           = ab_q[1];
   assign bus.B           = ab_q[0];
   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = done_q;
   assign bus.match_count = match_q;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_abro_stimulus_gen.sv
// tb/tb_abro_stimulus_gen.sv - generator paired with a behavioural ABRO detector, scoreboard checked
module tb_abro_stimulus_gen;
   logic clk;
   logic reset;
   logic force0;
   logic [1:0] det_q;
   int n_checks;
   int n_fail;

   typedef struct {
      int match;
      int err;
      int busy;
   } sb_t;
   sb_t sb[$];

   abro_stimulus_gen_if #(.HOLD_W(4), .REPS_W(4)) bus ();

   abro_stimulus_gen #(.HOLD_W(4), .REPS_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // detector: 11 -> 10 -> 01 reaches match (3), held under 01/00
   always @(posedge clk) begin
      if (!reset) begin
         det_q <= 2'd0;
      end else begin
         case (det_q)
            2'd0: det_q <= ({bus.A, bus.B} == 2'b11) ? 2'd1 : 2'd0;
            2'd1: det_q <= ({bus.A, bus.B} == 2'b11) ? 2'd1 :
                           ({bus.A, bus.B} == 2'b10) ? 2'd2 : 2'd0;
            2'd2: det_q <= ({bus.A, bus.B} == 2'b10) ? 2'd2 :
                           ({bus.A, bus.B} == 2'b01) ? 2'd3 :
                           ({bus.A, bus.B} == 2'b11) ? 2'd1 : 2'd0;
            default: det_q <= ({bus.A, bus.B} == 2'b11) ? 2'd1 :
                              (bus.A == 1'b0) ? 2'd3 : 2'd0;
         endcase
      end
   end

   assign bus.o_in = force0 ? 1'b0 : (det_q == 2'd3);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run_seq(input int h, input int r, input bit f0, input bit poke);
      int he, per, cyc, p, iter;
      logic [1:0] ab_exp;
      sb_t e, g;
      he  = (h == 0) ? 1 : h;
      per = 3 * he + 1;
      force0 = f0;
      @(negedge clk);
      bus.start       = 1'b1;
      bus.hold_cycles = h[3:0];
      bus.reps        = r[3:0];
      e.match = f0 ? 0 : r;
      e.err   = f0 ? 1 : 0;
      e.busy  = per * r;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      check("clr_match", bus.match_count, 0);
      check("clr_err", bus.err, 0);
      cyc  = 0;
      iter = 0;
      while (!bus.done && iter < 1000) begin
         p = cyc % per;
         ab_exp = (p < he) ? 2'b11 : (p < 2 * he) ? 2'b10 : (p < 3 * he) ? 2'b01 : 2'b00;
         check("ab", {bus.A, bus.B}, ab_exp);
         if (bus.busy) cyc++;
         if (poke) begin
            bus.start = (cyc == 2);
            if (cyc == 2) begin
               bus.reps        = 4'd7;
               bus.hold_cycles = 4'd5;
            end
         end
         iter++;
         @(negedge clk);
      end
      bus.start = 1'b0;
      check("done_seen", bus.done, 1);
      g = sb.pop_front();
      check("match", bus.match_count, g.match);
      check("err", bus.err, g.err);
      check("busy_cycles", cyc, g.busy);
      @(negedge clk);
      check("done_pulse", bus.done, 0);
      force0 = 1'b0;
   endtask

   initial begin
      int seen;
      n_checks = 0;
      n_fail   = 0;
      force0   = 1'b0;
      reset    = 1'b0;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.hold_cycles = '0;
      bus.reps        = '0;
      repeat (3) @(negedge clk);
      check("rst_ab", {bus.A, bus.B}, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_match", bus.match_count, 0);
      reset = 1'b1;

      run_seq(1, 1, 1'b0, 1'b0);
      run_seq(3, 4, 1'b0, 1'b0);
      run_seq(0, 2, 1'b0, 1'b0);
      run_seq(2, 3, 1'b1, 1'b0);
      run_seq(1, 1, 1'b0, 1'b0);
      run_seq(1, 2, 1'b0, 1'b1);

      // start with reps=0 is ignored
      @(negedge clk);
      bus.start = 1'b1; bus.reps = 4'd0; bus.hold_cycles = 4'd3;
      @(negedge clk);
      bus.start = 1'b0;
      check("reps0_busy", bus.busy, 0);
      seen = 0;
      repeat (5) begin
         if (bus.done || bus.busy) seen = 1;
         @(negedge clk);
      end
      check("reps0_quiet", seen, 0);

      // abort in PH_A of rep 2
      bus.start = 1'b1; bus.reps = 4'd5; bus.hold_cycles = 4'd2;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_in_ph_a", {bus.A, bus.B}, 2'b10);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_busy", bus.busy, 0);
      check("abort_ab", {bus.A, bus.B}, 0);
      check("abort_done", bus.done, 0);
      check("abort_match", bus.match_count, 1);
      check("abort_err", bus.err, 0);
      seen = 0;
      repeat (10) begin
         if (bus.done || bus.busy) seen = 1;
         @(negedge clk);
      end
      check("abort_quiet", seen, 0);

      // reset mid-PH_B of rep 2
      bus.start = 1'b1; bus.reps = 4'd2; bus.hold_cycles = 4'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (17) @(negedge clk);
      check("pre_rst_ab", {bus.A, bus.B}, 2'b01);
      check("pre_rst_match", bus.match_count, 1);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_ab", {bus.A, bus.B}, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_done", bus.done, 0);
      check("mid_rst_err", bus.err, 0);
      check("mid_rst_match", bus.match_count, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_busy", bus.busy, 0);
      check("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
